flash_reader: RTL and testbench

SPI initiator that reads a contiguous byte range from the serial flash (P25Q32U, mode 0, command 0x03 "read").
- Sits between the boot loader / cache fill logic and the flash pins; in simulation it is paired with the flash emulator.
- A request gives a 24-bit start address and a byte count. The block shifts out the command and address MSB-first, then returns bytes one at a time over a valid/ready handshake.
- SCK runs at clk/2 and pauses low while the consumer back-pressures.

---
 rtl/flash_pkg.sv | 22 ++
 rtl/spi_shifter.sv | 52 +++++
 rtl/flash_reader.sv | 219 +++++++++++++++++++++
 tb/tb_flash_reader.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_pkg.sv
// ---------------------------------------------------------------------------
// flash_pkg
// Shared definitions for the serial flash read path: controller state
// encoding, the flash read opcode and the flash address width.
// ---------------------------------------------------------------------------
package flash_pkg;

  typedef enum logic [2:0] {
    Idle    = 3'd0,
    Command = 3'd1,
    Address = 3'd2,
    Data    = 3'd3,
    Finish  = 3'd4
  } state_e;

  // Plain "read" opcode; shifted out first, MSB first.
  localparam logic [7:0] ReadCommand = 8'h03;

  // Address bits following the opcode (must be a multiple of 8).
  localparam int FlashAddressBitWidth = 24;

endpackage

// File: rtl/spi_shifter.sv
// ---------------------------------------------------------------------------
// spi_shifter
// 8-bit MSB-first shift register shared by the transmit (command/address)
// and receive (data) directions, with a bit counter marking the last bit.
//
// Ports:
//   clk, rst       system clock, synchronous active-high reset
//   i_load         load i_load_data and restart the bit counter
//   i_load_data    byte to load
//   i_shift        shift left by one, inserting i_shift_in at bit 0
//   i_shift_in     serial input bit (miso)
//   o_data         current register contents
//   o_msb          serial output bit (register bit 7)
//   o_last         bit counter sits on the eighth bit of the byte
// ---------------------------------------------------------------------------
module spi_shifter (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic [7:0] i_load_data,
  input  logic       i_shift,
  input  logic       i_shift_in,
  output logic [7:0] o_data,
  output logic       o_msb,
  output logic       o_last
);

  logic [7:0] r_data;
  logic [2:0] r_bit_cnt;

  // Shift register and bit counter; load has priority over shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data    <= 8'h00;
      r_bit_cnt <= 3'd0;
    end else if (i_load) begin
      r_data    <= i_load_data;
      r_bit_cnt <= 3'd0;
    end else if (i_shift) begin
      r_data    <= {r_data[6:0], i_shift_in};
      r_bit_cnt <= r_bit_cnt + 3'd1;
    end else begin
      r_data    <= r_data;
      r_bit_cnt <= r_bit_cnt;
    end
  end

  assign o_data = r_data;
  assign o_msb  = r_data[7];
  assign o_last = (r_bit_cnt == 3'd7);

endmodule

// File: rtl/flash_reader.sv
// ---------------------------------------------------------------------------
// flash_reader
// SPI mode-0 initiator reading a contiguous byte range from serial flash
// with opcode 0x03. Sends opcode + address MSB first, then returns bytes
// over a valid/ready handshake. SCK runs at clk/2 and parks low while the
// consumer back-pressures.
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   start         request strobe (only honoured in Idle)
//   address       first byte address, captured on start
//   byte_count    number of bytes, captured on start (0 = immediate done)
//   busy          high from the cycle after an accepted start until done
//   done          one-cycle completion pulse, cs_n already high
//   data_out      received byte, stable while data_valid
//   data_valid    data_out holds a byte
//   data_ready    consumer accepts when data_valid && data_ready
//   sclk, cs_n, mosi, miso   flash pins
// ---------------------------------------------------------------------------
module flash_reader
  import flash_pkg::*;
#(
  parameter int AddressBitWidth = FlashAddressBitWidth,
  parameter int CountBitWidth   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [AddressBitWidth-1:0] address,
  input  logic [CountBitWidth-1:0]   byte_count,
  output logic                       busy,
  output logic                       done,
  output logic [7:0]                 data_out,
  output logic                       data_valid,
  input  logic                       data_ready,
  output logic                       sclk,
  output logic                       cs_n,
  output logic                       mosi,
  input  logic                       miso
);

  localparam int AddressBytes = AddressBitWidth / 8;
  localparam logic [CountBitWidth-1:0] CountZero = CountBitWidth'(0);
  localparam logic [CountBitWidth-1:0] CountOne  = CountBitWidth'(1);

  state_e                     r_state;
  logic                       r_busy;
  logic                       r_done;
  logic [7:0]                 r_data_out;
  logic                       r_data_valid;
  logic                       r_sclk;
  logic                       r_cs_n;
  logic                       r_mosi;
  logic [AddressBitWidth-1:0] r_addr;
  logic [3:0]                 r_addr_left;
  logic [CountBitWidth-1:0]   r_count;

  logic       w_load;
  logic [7:0] w_load_data;
  logic       w_shift;
  logic [7:0] w_shift_data;
  logic       w_msb;
  logic       w_last;

  spi_shifter u_shifter (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_load),
    .i_load_data (w_load_data),
    .i_shift     (w_shift),
    .i_shift_in  (miso),
    .o_data      (w_shift_data),
    .o_msb       (w_msb),
    .o_last      (w_last)
  );

  // Shifter control: every sclk rising edge either shifts one bit or, on the
  // eighth bit of an outgoing byte, loads the next byte to transmit.
  always_comb begin
    w_load      = 1'b0;
    w_load_data = 8'h00;
    w_shift     = 1'b0;
    case (r_state)
      Idle: begin
        if (start && (byte_count != CountZero)) begin
          w_load      = 1'b1;
          w_load_data = ReadCommand;
        end else begin
          w_load = 1'b0;
        end
      end
      Command, Address: begin
        if (!r_sclk && w_last) begin
          w_load = 1'b1;
          // After the final address byte the register is cleared so that
          // the data phase starts from a known value.
          if ((r_state == Address) && (r_addr_left == 4'd0)) begin
            w_load_data = 8'h00;
          end else begin
            w_load_data = r_addr[AddressBitWidth-1 -: 8];
          end
        end else if (!r_sclk) begin
          w_shift = 1'b1;
        end else begin
          w_shift = 1'b0;
        end
      end
      Data: begin
        // No shifting while a received byte waits for the consumer.
        if (!r_sclk && !r_data_valid) begin
          w_shift = 1'b1;
        end else begin
          w_shift = 1'b0;
        end
      end
      default: begin
        w_shift = 1'b0;
      end
    endcase
  end

  // Transfer FSM: sclk phase, chip select, mosi, handshake and byte counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= Idle;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_data_out   <= 8'h00;
      r_data_valid <= 1'b0;
      r_sclk       <= 1'b0;
      r_cs_n       <= 1'b1;
      r_mosi       <= 1'b0;
      r_addr       <= '0;
      r_addr_left  <= 4'd0;
      r_count      <= CountZero;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        Idle: begin
          if (start && (byte_count == CountZero)) begin
            r_done <= 1'b1;
          end else if (start) begin
            r_state <= Command;
            r_busy  <= 1'b1;
            r_cs_n  <= 1'b0;
            r_sclk  <= 1'b0;
            r_mosi  <= ReadCommand[7];
            r_addr  <= address;
            r_count <= byte_count;
          end
        end
        Command, Address: begin
          if (!r_sclk) begin
            r_sclk <= 1'b1;
            if (w_last) begin
              if (r_state == Command) begin
                r_state     <= Address;
                r_addr      <= {r_addr[AddressBitWidth-9:0], 8'h00};
                r_addr_left <= 4'(AddressBytes - 1);
              end else if (r_addr_left == 4'd0) begin
                r_state <= Data;
              end else begin
                r_addr      <= {r_addr[AddressBitWidth-9:0], 8'h00};
                r_addr_left <= r_addr_left - 4'd1;
              end
            end
          end else begin
            // Entering a low phase: present the next bit.
            r_sclk <= 1'b0;
            r_mosi <= w_msb;
          end
        end
        Data: begin
          if (r_data_valid) begin
            // Byte pending: sclk parks low until it is taken.
            r_sclk <= 1'b0;
            if (data_ready) begin
              r_data_valid <= 1'b0;
              r_count      <= r_count - CountOne;
              if (r_count == CountOne) begin
                r_state <= Finish;
                r_cs_n  <= 1'b1;
              end
            end
          end else if (!r_sclk) begin
            // Rising sclk samples miso; the eighth sample completes a byte.
            r_sclk <= 1'b1;
            if (w_last) begin
              r_data_out   <= {w_shift_data[6:0], miso};
              r_data_valid <= 1'b1;
            end
          end else begin
            r_sclk <= 1'b0;
            r_mosi <= 1'b0;
          end
        end
        Finish: begin
          r_state <= Idle;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_sclk  <= 1'b0;
          r_cs_n  <= 1'b1;
        end
        default: begin
          r_state <= Idle;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign sclk       = r_sclk;
  assign cs_n       = r_cs_n;
  assign mosi       = r_mosi;

endmodule

// File: tb/tb_flash_reader.sv
// ---------------------------------------------------------------------------
// tb_flash_reader
// Directed bench for flash_reader paired with a small mode-0 flash model
// (12-bit address, byte n holds n[7:0]). The model also records the first
// 32 bits seen on mosi at sclk rising edges.
// Cycle numbering: cycle 0 is the cycle whose closing edge samples start;
// outputs are observed on the falling clock edge inside each cycle.
// ---------------------------------------------------------------------------
module tb_flash_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [23:0] address;
  logic [15:0] byte_count;
  logic        busy;
  logic        done;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        data_ready;
  logic        sclk;
  logic        cs_n;
  logic        mosi;
  logic        miso = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Results of the most recent do_read.
  logic [7:0] got_q[$];
  int first_valid, second_valid, last_hs, done_cnt, done_cyc;
  int csn_hi_cnt, stall_bad, stall_seen;
  logic [7:0] stall_ref;
  int zero_bad;

  // Flash model state.
  logic [7:0]  mem [0:4095];
  int          em_bits = 0;
  logic [31:0] em_cmdaddr = 32'h0;
  int          eidx;
  logic [11:0] ea;
  logic [7:0]  eb;

  flash_reader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .address    (address),
    .byte_count (byte_count),
    .busy       (busy),
    .done       (done),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .sclk       (sclk),
    .cs_n       (cs_n),
    .mosi       (mosi),
    .miso       (miso)
  );

  // Clock generator.
  always #5 clk = ~clk;

  // Flash contents: byte n = n[7:0].
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'(i);
  end

  // Flash model: new transaction on chip select falling.
  always @(negedge cs_n) em_bits = 0;

  // Flash model: capture opcode and address on sclk rising.
  always @(posedge sclk) begin
    if (!cs_n) begin
      if (em_bits < 32) em_cmdaddr = {em_cmdaddr[30:0], mosi};
      em_bits = em_bits + 1;
    end
  end

  // Flash model: drive data MSB first on sclk falling.
  always @(negedge sclk) begin
    if (!cs_n && em_bits >= 32) begin
      eidx = em_bits - 32;
      ea   = em_cmdaddr[11:0] + 12'(eidx / 8);
      eb   = mem[ea];
      miso = eb[3'(7 - (eidx % 8))];
    end
  end

  // Watchdog against a hung run.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One read transaction; optional stall on byte stall_idx for stall_len
  // cycles and optional extra start pulse in cycle restart_cyc.
  task automatic do_read(input logic [23:0] a, input logic [15:0] n,
                         input int stall_idx, input int stall_len, input int restart_cyc);
    int c;
    int idx;
    int stall_cnt;
    int valid_seen;
    got_q.delete();
    first_valid = -1; second_valid = -1; last_hs = -1;
    done_cnt = 0; done_cyc = -1; csn_hi_cnt = 0; stall_bad = 0;
    stall_ref = 8'h00;
    idx = 0; stall_cnt = 0; valid_seen = 0;
    address = a; byte_count = n; start = 1'b1; data_ready = 1'b1;
    @(negedge clk);
    c = 1;
    start = 1'b0;
    while (c < 800 && (done_cyc < 0 || c <= done_cyc + 3)) begin
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (last_hs >= 0 && (c == last_hs + 1 || c == last_hs + 2) && cs_n === 1'b1) csn_hi_cnt++;
      if (data_valid === 1'b1 && valid_seen == idx) begin
        valid_seen++;
        if (first_valid < 0) first_valid = c;
        else if (second_valid < 0) second_valid = c;
      end
      start = (c == restart_cyc);
      if (c == restart_cyc) begin
        address = 24'h000300;
        byte_count = 16'd9;
      end
      if (data_valid === 1'b1 && idx == stall_idx && stall_cnt < stall_len) begin
        if (stall_cnt == 0) stall_ref = data_out;
        else if (sclk !== 1'b0 || data_out !== stall_ref) stall_bad++;
        stall_cnt++;
        data_ready = 1'b0;
      end else begin
        data_ready = 1'b1;
        if (data_valid === 1'b1) begin
          got_q.push_back(data_out);
          idx++;
          last_hs = c;
        end
      end
      @(negedge clk);
      c++;
    end
    start = 1'b0;
    data_ready = 1'b1;
    stall_seen = stall_cnt;
    check("read_completed", 32'(done_cyc >= 0), 32'h1);
  endtask

  task automatic check_bytes(input string tag, input logic [23:0] a, input int n);
    logic [7:0] v;
    check({tag, "_count"}, 32'(got_q.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (i < got_q.size()) v = got_q[i];
      else v = 8'hxx;
      check({tag, "_byte"}, 32'(v), 32'(8'(a[7:0] + 8'(i))));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; address = 24'h0; byte_count = 16'h0; data_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cs_n", 32'(cs_n), 32'h1);
    check("rst_sclk", 32'(sclk), 32'h0);
    check("rst_mosi", 32'(mosi), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_valid", 32'(data_valid), 32'h0);
    check("rst_data", 32'(data_out), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Plain read of 4 bytes from 0x10.
    do_read(24'h000010, 16'd4, -1, 0, -1);
    check_bytes("plain", 24'h000010, 4);
    check("plain_first_valid", 32'(first_valid), 32'd80);
    check("plain_second_valid", 32'(second_valid), 32'd96);
    check("plain_last_hs", 32'(last_hs), 32'd128);
    check("plain_done_cnt", 32'(done_cnt), 32'd1);
    check("plain_done_cyc", 32'(done_cyc), 32'd130);
    check("plain_csn_high", 32'(csn_hi_cnt), 32'd2);
    check("plain_mosi_bits", em_cmdaddr, 32'h03000010);
    check("plain_sclk_rises", 32'(em_bits), 32'd64);
    check("plain_busy_end", 32'(busy), 32'h0);

    // Same read, consumer holds off the second byte for 10 cycles.
    do_read(24'h000010, 16'd4, 1, 10, -1);
    check_bytes("stall", 24'h000010, 4);
    check("stall_cycles", 32'(stall_seen), 32'd10);
    check("stall_held", 32'(stall_bad), 32'd0);
    check("stall_data", 32'(stall_ref), 32'h11);
    check("stall_last_hs", 32'(last_hs), 32'd138);
    check("stall_done_cnt", 32'(done_cnt), 32'd1);
    check("stall_done_cyc", 32'(done_cyc), 32'd140);

    // Start pulsed again while busy must be ignored.
    do_read(24'h000010, 16'd4, -1, 0, 20);
    check_bytes("restart", 24'h000010, 4);
    check("restart_last_hs", 32'(last_hs), 32'd128);
    check("restart_done_cnt", 32'(done_cnt), 32'd1);

    // Zero-length request.
    address = 24'h000055; byte_count = 16'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("zero_done_c1", 32'(done), 32'h1);
    check("zero_busy_c1", 32'(busy), 32'h0);
    check("zero_cs_n_c1", 32'(cs_n), 32'h1);
    zero_bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (cs_n !== 1'b1 || busy !== 1'b0 || done !== 1'b0) zero_bad++;
    end
    check("zero_quiet", 32'(zero_bad), 32'd0);

    // Reset in the address phase, then a fresh read.
    address = 24'h000010; byte_count = 16'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (39) @(negedge clk);
    check("mid_cs_n_low", 32'(cs_n), 32'h0);
    check("mid_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_cs_n", 32'(cs_n), 32'h1);
    check("midrst_sclk", 32'(sclk), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_valid", 32'(data_valid), 32'h0);
    check("midrst_mosi", 32'(mosi), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    do_read(24'h000020, 16'd1, -1, 0, -1);
    check_bytes("after_rst", 24'h000020, 1);
    check("after_rst_first_valid", 32'(first_valid), 32'd80);
    check("after_rst_done_cyc", 32'(done_cyc), 32'd82);
    check("after_rst_done_cnt", 32'(done_cnt), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
